sys_stim_bridge: RTL
====================

SYS_STIM_BRIDGE -- requirements
Module: sys_stim_bridge

Interface
REQ-001 SHALL have parameter AW, default 16, meaning address width of ibus_radr/ibus_wadr.
REQ-002 SHALL have parameter DW, default 16, meaning data width of ibus_wdata/ibus_rdata.
REQ-003 SHALL have parameter RD_LAT, default 1 (range 1..15), meaning cycles from ren pulse to valid ibus_rdata.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rx  input  1  serial command stream, one bit sampled per clk.
REQ-007 SHALL have port tx  output  1  serial read-response stream, one bit per clk.
REQ-008 SHALL have port ren  output  1  read strobe to array bus, one-cycle pulse.
REQ-009 SHALL have port ibus_radr  output  AW  read address.
REQ-010 SHALL have port ibus_rdata  input  DW  read data from array bus.
REQ-011 SHALL have port wen  output  1  write strobe to array bus, one-cycle pulse.
REQ-012 SHALL have port ibus_wadr  output  AW  write address.
REQ-013 SHALL have port ibus_wdata  output  DW  write data.
REQ-014 SHALL have port busy  output  1  high whenever FSM is not in IDLE.

Function
REQ-015 Command frame on rx SHALL be: start bit 1, OP[1:0], ADR[AW-1:0], then DATA[DW-1:0] only for writes; all fields MSB first.
REQ-016 OP encoding SHALL be 2'b00 NOP, 2'b01 READ, 2'b10 WRITE, 2'b11 reserved (treated as NOP).
REQ-017 FSM states SHALL be IDLE, OP, ADR, DATA, ISSUE, RWAIT, TXOUT.
REQ-018 IDLE: rx=0 stays IDLE; rx=1 -> OP with bit counter cleared.
REQ-019 OP: after 2 bits -> ADR for READ/WRITE, -> IDLE for NOP/reserved.
REQ-020 ADR: after AW bits -> DATA for WRITE, -> ISSUE for READ.
REQ-021 DATA: after DW bits -> ISSUE.
REQ-022 ISSUE SHALL last exactly one cycle: WRITE asserts wen with ibus_wadr/ibus_wdata valid, then -> IDLE; READ asserts ren with ibus_radr valid, then -> RWAIT.
REQ-023 wen/ren SHALL assert in the cycle after the last frame bit is sampled; never both high together.
REQ-024 RWAIT SHALL count RD_LAT cycles after the ren cycle, capture ibus_rdata on the last count, then -> TXOUT.
REQ-025 TXOUT SHALL drive tx = 1 (start bit) then DW captured bits MSB first, then -> IDLE; total DW+1 cycles.
REQ-026 tx SHALL be 0 in every state except TXOUT.
REQ-027 rx SHALL be ignored in ISSUE, RWAIT and TXOUT; a new start bit is recognised only from IDLE.
REQ-028 ibus_radr, ibus_wadr, ibus_wdata SHALL hold last issued value until next ISSUE of the same type.
REQ-029 Bit counter SHALL be width clog2(max(AW,DW)+1) and SHALL clear on every state change.

Reset
REQ-030 On rst_n low, FSM SHALL go to IDLE asynchronously; tx, ren, wen, busy = 0; ibus_radr, ibus_wadr, ibus_wdata, capture and shift registers = 0.
REQ-031 Reset mid-frame or mid-TXOUT SHALL abort without issuing any strobe; first rx=1 after release starts a new frame.

Structure
REQ-032 OP codes and state encoding SHALL live in shared package sys_stim_pkg.
REQ-033 TXOUT serializer (load, start bit, shift, done) SHALL be sub-module sys_stim_ser, parameterised by DW.

Verification (AW=16, DW=16, RD_LAT=2)
REQ-034 WRITE frame adr 0x0012, data 0xA5C3 -> wen pulse one cycle, 35 cycles after start bit, ibus_wadr=0x0012, ibus_wdata=0xA5C3, ren=0.
REQ-035 READ adr 0x0004, ibus_rdata model returns 0x1234 two cycles after ren -> tx emits 1 then 0001001000110100; busy drops after last bit.
REQ-036 NOP frame (1,00) and reserved (1,11) -> back to IDLE after 3 cycles, no strobes, tx stays 0.
REQ-037 Start bit driven during TXOUT -> ignored; frame completes unchanged, no extra strobe.
REQ-038 rst_n low in ADR of a WRITE -> all outputs 0, no wen; following WRITE 0x0001/0xFFFF issues correctly.
REQ-039 Back-to-back WRITE frames (second start bit in cycle after ISSUE) -> two wen pulses, correct addresses/data each.

Source files
------------

// File: rtl/sys_stim_pkg.sv
// rtl/sys_stim_pkg.sv - shared op codes, FSM states and helpers for the stimulus bridge
package sys_stim_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OP    = 3'd1,
        ST_ADR   = 3'd2,
        ST_DATA  = 3'd3,
        ST_ISSUE = 3'd4,
        ST_RWAIT = 3'd5,
        ST_TXOUT = 3'd6
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sys_stim_ser.sv
// rtl/sys_stim_ser.sv - read-response serializer: start bit then DW data bits MSB first
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load, load_data   one-cycle load of the captured read word
//   tx                serial output, 0 when idle
//   done              high in the last data-bit cycle
module sys_stim_ser #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    output logic          tx,
    output logic          done
);

    localparam int SCW = $clog2(DW + 1);

    logic [DW-1:0]  shift_q;
    logic [SCW-1:0] cnt_q;
    logic           active_q;

    // cnt_q == 0 is the start-bit cycle; 1..DW are the data bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (load) begin
            shift_q  <= load_data;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                shift_q <= {shift_q[DW-2:0], 1'b0};
                if (cnt_q == SCW'(DW)) begin
                    cnt_q    <= '0;
                    active_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign tx   = active_q & ((cnt_q == '0) | shift_q[DW-1]);
    assign done = active_q & (cnt_q == SCW'(DW));

endmodule

// File: rtl/sys_stim_bridge.sv
// rtl/sys_stim_bridge.sv - serial command frame to array-bus read/write bridge
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rx                         serial command: 1, OP[1:0], ADR, DATA (writes only), MSB first
//   tx                         serial read response: 1 then DW bits MSB first
//   ren, ibus_radr, ibus_rdata read strobe, address, returned data
//   wen, ibus_wadr, ibus_wdata write strobe, address, data
//   busy                       high whenever the FSM is not idle
module sys_stim_bridge
    import sys_stim_pkg::*;
#(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx,
    output logic          tx,
    output logic          ren,
    output logic [AW-1:0] ibus_radr,
    input  logic [DW-1:0] ibus_rdata,
    output logic          wen,
    output logic [AW-1:0] ibus_wadr,
    output logic [DW-1:0] ibus_wdata,
    output logic          busy
);

    // Wide enough for the longest frame field and for the read-wait count.
    localparam int CW = $clog2(max_int(max_int(AW, DW), RD_LAT) + 1);

    state_e         state_q;
    state_e         state_d;
    logic [CW-1:0]  cnt_q;
    logic [1:0]     op_q;
    logic [AW-1:0]  adr_sr;
    logic [DW-2:0]  data_sr;

    logic [1:0]     op_next;
    logic [AW-1:0]  adr_next;
    logic [DW-1:0]  data_next;

    logic           ser_load;
    logic           ser_tx;
    logic           ser_done;

    // Shift values including the bit on rx this cycle, so the final bit of a
    // field is usable in the same edge that leaves the state.
    assign op_next   = {op_q[0], rx};
    assign adr_next  = {adr_sr[AW-2:0], rx};
    assign data_next = {data_sr, rx};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rx) state_d = ST_OP;
            end
            ST_OP: begin
                if (cnt_q == CW'(1)) begin
                    if (op_next == OP_READ || op_next == OP_WRITE) state_d = ST_ADR;
                    else                                           state_d = ST_IDLE;
                end
            end
            ST_ADR: begin
                if (cnt_q == CW'(AW - 1)) begin
                    state_d = (op_q == OP_WRITE) ? ST_DATA : ST_ISSUE;
                end
            end
            ST_DATA: begin
                if (cnt_q == CW'(DW - 1)) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = (op_q == OP_READ) ? ST_RWAIT : ST_IDLE;
            end
            ST_RWAIT: begin
                if (cnt_q == CW'(RD_LAT - 1)) state_d = ST_TXOUT;
            end
            ST_TXOUT: begin
                if (ser_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            adr_sr     <= '0;
            data_sr    <= '0;
            ibus_radr  <= '0;
            ibus_wadr  <= '0;
            ibus_wdata <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
            case (state_q)
                ST_OP: begin
                    op_q <= op_next;
                end
                ST_ADR: begin
                    adr_sr <= adr_next;
                    if (state_d == ST_ISSUE) ibus_radr <= adr_next;
                end
                ST_DATA: begin
                    data_sr <= data_next[DW-2:0];
                    if (state_d == ST_ISSUE) begin
                        ibus_wadr  <= adr_sr;
                        ibus_wdata <= data_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read data is captured by the serializer on the last wait cycle.
    assign ser_load = (state_q == ST_RWAIT) && (cnt_q == CW'(RD_LAT - 1));

    sys_stim_ser #(
        .DW (DW)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ser_load),
        .load_data (ibus_rdata),
        .tx        (ser_tx),
        .done      (ser_done)
    );

    assign wen  = (state_q == ST_ISSUE) && (op_q == OP_WRITE);
    assign ren  = (state_q == ST_ISSUE) && (op_q == OP_READ);
    assign busy = (state_q != ST_IDLE);
    assign tx   = (state_q == ST_TXOUT) & ser_tx;

endmodule
